// File: rtl/bayer_2x2_binner_if.sv
// Sensor-side bundle for the 2x2 Bayer binner: raw pixel stream in, line buffer feed,
// half-resolution RGB stream out.
interface bayer_2x2_binner_if #(
   parameter int unsigned DEPTH = 12
);
   localparam int unsigned CoordW = 11;

   logic              frame_start;
   logic              pix_valid;
   logic [DEPTH-1:0]  pix_data;
   logic [DEPTH-1:0]  lb_tap0;
   logic              lb_shift;
   logic [DEPTH-1:0]  lb_data;
   logic              rgb_valid;
   logic [DEPTH-1:0]  red;
   logic [DEPTH-1:0]  green;
   logic [DEPTH-1:0]  blue;
   logic [CoordW-1:0] out_x;
   logic [CoordW-1:0] out_y;
   logic              frame_done;

   modport master (
      output frame_start, pix_valid, pix_data, lb_tap0,
      input  lb_shift, lb_data, rgb_valid, red, green, blue, out_x, out_y, frame_done
   );

   modport slave (
      input  frame_start, pix_valid, pix_data, lb_tap0,
      output lb_shift, lb_data, rgb_valid, red, green, blue, out_x, out_y, frame_done
   );
endinterface

// File: rtl/bayer_2x2_binner.sv
// Bins each GRBG 2x2 quad into one RGB pixel at half resolution, using the line
// buffer's previous-row tap for the upper half of the quad.
module bayer_2x2_binner #(
   parameter int unsigned WIDTH  = 1280,
   parameter int unsigned HEIGHT = 960,
   parameter int unsigned DEPTH  = 12
) (
   input logic                clk,
   input logic                rst_n,
   bayer_2x2_binner_if.slave  bus
);
   localparam int unsigned CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned CoordW = 11;

   logic [CW-1:0]     col_q, col_d, col_cur;
   logic [RW-1:0]     row_q, row_d, row_cur;
   logic [DEPTH-1:0]  hold_cur_q, hold_cur_d;
   logic [DEPTH-1:0]  hold_prev_q, hold_prev_d;
   logic              rgb_valid_q, rgb_valid_d;
   logic [DEPTH-1:0]  red_q, red_d;
   logic [DEPTH-1:0]  green_q, green_d;
   logic [DEPTH-1:0]  blue_q, blue_d;
   logic [CoordW-1:0] out_x_q, out_x_d;
   logic [CoordW-1:0] out_y_q, out_y_d;
   logic              frame_done_q, frame_done_d;
   logic [DEPTH:0]    g_sum;

   // Line buffer advances with every accepted pixel.
   assign bus.lb_shift = bus.pix_valid;
   assign bus.lb_data  = bus.pix_data;

   // frame_start retargets the current pixel to (0,0) before any wrap decision.
   assign col_cur = bus.frame_start ? '0 : col_q;
   assign row_cur = bus.frame_start ? '0 : row_q;
   assign g_sum   = {1'b0, hold_prev_q} + {1'b0, bus.pix_data};

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_cur_d   = hold_cur_q;
      hold_prev_d  = hold_prev_q;
      rgb_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      red_d        = red_q;
      green_d      = green_q;
      blue_d       = blue_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;

      if (bus.pix_valid) begin
         if (col_cur == CW'(WIDTH - 1)) begin
            col_d = '0;
            row_d = (row_cur == RW'(HEIGHT - 1)) ? '0 : row_cur + RW'(1);
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end

         // Left column of the quad: G1/B now, R/G2 arrive with the odd column.
         if (!col_cur[0]) begin
            hold_cur_d  = bus.pix_data;
            hold_prev_d = bus.lb_tap0;
         end

         if (row_cur[0] && col_cur[0]) begin
            rgb_valid_d  = 1'b1;
            red_d        = bus.lb_tap0;
            blue_d       = hold_cur_q;
            green_d      = DEPTH'(g_sum >> 1);
            out_x_d      = CoordW'(col_cur >> 1);
            out_y_d      = CoordW'(row_cur >> 1);
            frame_done_d = (row_cur == RW'(HEIGHT - 1)) && (col_cur == CW'(WIDTH - 1));
         end
      end else if (bus.frame_start) begin
         col_d = '0;
         row_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_cur_q   <= '0;
         hold_prev_q  <= '0;
         rgb_valid_q  <= 1'b0;
         red_q        <= '0;
         green_q      <= '0;
         blue_q       <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_cur_q   <= hold_cur_d;
         hold_prev_q  <= hold_prev_d;
         rgb_valid_q  <= rgb_valid_d;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.rgb_valid  = rgb_valid_q;
   assign bus.red        = red_q;
   assign bus.green      = green_q;
   assign bus.blue       = blue_q;
   assign bus.out_x      = out_x_q;
   assign bus.out_y      = out_y_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bayer_2x2_binner.sv
// Scoreboard bench for bayer_2x2_binner on a 4x4 frame with a behavioural line buffer.
module tb_bayer_2x2_binner;
   localparam int unsigned W = 4;
   localparam int unsigned H = 4;
   localparam int unsigned D = 12;

   typedef struct packed {
      logic [D-1:0] r;
      logic [D-1:0] g;
      logic [D-1:0] b;
      logic [10:0]  x;
      logic [10:0]  y;
      logic         fd;
      logic [31:0]  cyc;
   } pulse_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cyc = 0;
   int          n_asserts = 0;
   int          n_fail = 0;
   int          mr = 0;
   int          mc = 0;
   logic [D-1:0] img [H][W];
   logic [D-1:0] lb_sr [W];
   pulse_t       exp_q[$];
   pulse_t       obs_q[$];
   pulse_t       ref_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bayer_2x2_binner_if #(.DEPTH(D)) bus ();

   bayer_2x2_binner #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Line buffer: oldest tap is the sample shifted in W shifts ago.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < W; i++) lb_sr[i] <= '0;
      end else if (bus.lb_shift) begin
         lb_sr[0] <= bus.lb_data;
         for (int i = 1; i < W; i++) lb_sr[i] <= lb_sr[i-1];
      end
   end
   assign bus.lb_tap0 = lb_sr[W-1];

   // Output monitor: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      pulse_t o;
      pulse_t e;
      if (rst_n === 1'b1 && bus.rgb_valid === 1'b1) begin
         o.r = bus.red; o.g = bus.green; o.b = bus.blue;
         o.x = bus.out_x; o.y = bus.out_y; o.fd = bus.frame_done; o.cyc = cyc;
         obs_q.push_back(o);
         n_asserts++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got r=%0h g=%0h b=%0h x=%0d y=%0d at cyc %0d, required no pulse",
                     o.r, o.g, o.b, o.x, o.y, o.cyc);
         end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL pulse: got r=%0h g=%0h b=%0h x=%0d y=%0d fd=%0b cyc=%0d, required r=%0h g=%0h b=%0h x=%0d y=%0d fd=%0b cyc=%0d",
                        o.r, o.g, o.b, o.x, o.y, o.fd, o.cyc, e.r, e.g, e.b, e.x, e.y, e.fd, e.cyc);
            end
         end
      end else if (rst_n === 1'b1) begin
         n_asserts++;
         if (bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done_alone: got frame_done=%0b without rgb_valid, required 0", bus.frame_done);
         end
      end
   end

   task automatic send_pixel(input logic [D-1:0] v, input logic fs);
      pulse_t e;
      logic [D:0] sum;
      @(negedge clk);
      bus.frame_start = fs;
      bus.pix_valid   = 1'b1;
      bus.pix_data    = v;
      if (fs) begin mr = 0; mc = 0; end
      img[mr][mc] = v;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
         sum   = {1'b0, img[mr-1][mc-1]} + {1'b0, v};
         e.r   = img[mr-1][mc];
         e.b   = img[mr][mc-1];
         e.g   = sum[D:1];
         e.x   = 11'(mc / 2);
         e.y   = 11'(mr / 2);
         e.fd  = (mr == H - 1) && (mc == W - 1);
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
      #1;
      n_asserts++;
      if (bus.lb_shift !== 1'b1 || bus.lb_data !== v) begin
         n_fail++;
         $display("FAIL lb_feed: got lb_shift=%0b lb_data=%0h, required 1 / %0h", bus.lb_shift, bus.lb_data, v);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.frame_start = 1'b0;
         bus.pix_valid   = 1'b0;
         #1;
         n_asserts++;
         if (bus.lb_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_idle: got lb_shift=%0b, required 0", bus.lb_shift);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      idle(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
      repeat (3) @(negedge clk);
      n_asserts++;
      if ({bus.rgb_valid, bus.frame_done, bus.lb_shift} !== 3'b000 ||
          {bus.red, bus.green, bus.blue} !== '0 || {bus.out_x, bus.out_y} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got v=%0b fd=%0b sh=%0b r=%0h g=%0h b=%0h x=%0d y=%0d, required all 0",
                  bus.rgb_valid, bus.frame_done, bus.lb_shift, bus.red, bus.green, bus.blue, bus.out_x, bus.out_y);
      end
      rst_n = 1'b1;
      // Partial frame up to (1,0), then reset discards it.
      for (int i = 0; i < 5; i++) send_pixel(D'(16 * (i / W) + (i % W)), i == 0);
      @(negedge clk);
      bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
      rst_n = 1'b0;
      exp_q.delete(); mr = 0; mc = 0;
      #1;
      n_asserts++;
      if (bus.rgb_valid !== 1'b0 || bus.lb_shift !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_row: got rgb_valid=%0b lb_shift=%0b, required 0/0", bus.rgb_valid, bus.lb_shift);
      end
      @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      for (int i = 0; i < W * H; i++) send_pixel(D'(100 + i), i == 0);
      drain();
      n_asserts++;
      if (obs_q.size() != 4 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_resume_count: got %0d pulses (%0d pending), required 4 (0)", obs_q.size(), exp_q.size());
      end else begin
         n_asserts++;
         if (obs_q[0].r !== 12'd101 || obs_q[0].b !== 12'd104 || obs_q[0].g !== 12'd102) begin
            n_fail++;
            $display("FAIL reset_resume_first: got r=%0d b=%0d g=%0d, required 101/104/102", obs_q[0].r, obs_q[0].b, obs_q[0].g);
         end
      end
   endtask

   task automatic test_stream();
      obs_q.delete();
      for (int i = 0; i < W * H; i++) send_pixel(D'(16 * (i / W) + (i % W)), i == 0);
      drain();
      n_asserts++;
      if (obs_q.size() != 4) begin
         n_fail++;
         $display("FAIL stream_count: got %0d pulses, required 4", obs_q.size());
      end else begin
         n_asserts++;
         if (obs_q[0].r !== 12'd1 || obs_q[0].b !== 12'd16 || obs_q[0].g !== 12'd8 ||
             obs_q[0].x !== 11'd0 || obs_q[0].y !== 11'd0 || obs_q[0].fd !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_first: got r=%0d b=%0d g=%0d x=%0d y=%0d fd=%0b, required 1/16/8/0/0/0",
                     obs_q[0].r, obs_q[0].b, obs_q[0].g, obs_q[0].x, obs_q[0].y, obs_q[0].fd);
         end
         n_asserts++;
         if (obs_q[1].x !== 11'd1 || obs_q[1].y !== 11'd0 || obs_q[2].x !== 11'd0 || obs_q[2].y !== 11'd1 ||
             obs_q[1].fd !== 1'b0 || obs_q[2].fd !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_coords: got (%0d,%0d) fd%0b (%0d,%0d) fd%0b, required (1,0) fd0 (0,1) fd0",
                     obs_q[1].x, obs_q[1].y, obs_q[1].fd, obs_q[2].x, obs_q[2].y, obs_q[2].fd);
         end
         n_asserts++;
         if (obs_q[3].r !== 12'd35 || obs_q[3].b !== 12'd50 || obs_q[3].g !== 12'd42 ||
             obs_q[3].x !== 11'd1 || obs_q[3].y !== 11'd1 || obs_q[3].fd !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_last: got r=%0d b=%0d g=%0d x=%0d y=%0d fd=%0b, required 35/50/42/1/1/1",
                     obs_q[3].r, obs_q[3].b, obs_q[3].g, obs_q[3].x, obs_q[3].y, obs_q[3].fd);
         end
      end
      ref_q = obs_q;
   endtask

   task automatic test_gaps();
      obs_q.delete();
      for (int i = 0; i < W * H; i++) begin
         send_pixel(D'(16 * (i / W) + (i % W)), i == 0);
         idle(int'($urandom_range(1, 5)));
      end
      drain();
      n_asserts++;
      if (obs_q.size() != ref_q.size()) begin
         n_fail++;
         $display("FAIL gaps_count: got %0d pulses, required %0d", obs_q.size(), ref_q.size());
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i].r !== ref_q[i].r || obs_q[i].g !== ref_q[i].g || obs_q[i].b !== ref_q[i].b ||
                obs_q[i].x !== ref_q[i].x || obs_q[i].y !== ref_q[i].y || obs_q[i].fd !== ref_q[i].fd) begin
               n_fail++;
               $display("FAIL gaps_pulse%0d: got r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                        i, obs_q[i].r, obs_q[i].g, obs_q[i].b, ref_q[i].r, ref_q[i].g, ref_q[i].b);
            end
         end
      end
   endtask

   task automatic test_green_sat();
      logic [D-1:0] v;
      obs_q.delete();
      for (int i = 0; i < W * H; i++) begin
         v = '0;
         if (i == 0 || i == 5 || i == 2) v = 12'hFFF;
         send_pixel(v, i == 0);
      end
      drain();
      n_asserts++;
      if (obs_q.size() != 4) begin
         n_fail++;
         $display("FAIL sat_count: got %0d pulses, required 4", obs_q.size());
      end else begin
         n_asserts++;
         if (obs_q[0].g !== 12'hFFF) begin
            n_fail++;
            $display("FAIL green_max: got %0h, required fff", obs_q[0].g);
         end
         n_asserts++;
         if (obs_q[1].g !== 12'h7FF) begin
            n_fail++;
            $display("FAIL green_half: got %0h, required 7ff", obs_q[1].g);
         end
      end
   endtask

   task automatic test_frame_start();
      obs_q.delete();
      for (int i = 0; i < 11; i++) send_pixel(D'(16 * (i / W) + (i % W)), i == 0);
      for (int i = 0; i < W * H; i++) send_pixel(D'(200 + i), i == 0);
      drain();
      n_asserts++;
      if (obs_q.size() != 6) begin
         n_fail++;
         $display("FAIL fs_count: got %0d pulses, required 6", obs_q.size());
      end else begin
         n_asserts++;
         if (obs_q[2].x !== 11'd0 || obs_q[2].y !== 11'd0 || obs_q[2].r !== 12'd201 ||
             obs_q[2].b !== 12'd204 || obs_q[2].g !== 12'd202 || obs_q[2].fd !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_first: got x=%0d y=%0d r=%0d b=%0d g=%0d fd=%0b, required 0/0/201/204/202/0",
                     obs_q[2].x, obs_q[2].y, obs_q[2].r, obs_q[2].b, obs_q[2].g, obs_q[2].fd);
         end
         n_asserts++;
         if (obs_q[5].fd !== 1'b1 || obs_q[1].fd !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_done: got fd[1]=%0b fd[5]=%0b, required 0/1", obs_q[1].fd, obs_q[5].fd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_gaps();
      test_green_sat();
      test_frame_start();
      n_asserts++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending: got %0d unmatched expectations, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bayer_2x2_binner.md
Name: bayer_2x2_binner

Overview:
- Consumes raw Bayer pixels from the sensor capture path, together with the previous-row tap of the row line buffer.
- Produces one RGB pixel per 2x2 Bayer quad, at half resolution, with X/Y coordinates.
- Drives the line buffer shift enable, so buffer and binner advance in lockstep.
- Sits directly downstream of the line buffer and upstream of the RGB frame writer.

Parameters:
- WIDTH, 1280, raw pixels per row; must be even and equal the line buffer width.
- HEIGHT, 960, raw rows per frame; must be even.
- DEPTH, 12, bits per raw sample and per output colour channel.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  synchronous pulse; next accepted pixel is raw (0,0).
- pix_valid  input  1  pix_data is a valid raw sample this cycle.
- pix_data  input  DEPTH  raw Bayer sample at (row r, col c).
- lb_tap0  input  DEPTH  line buffer oldest tap; equals raw (r-1,c) in the cycle (r,c) is presented.
- lb_shift  output  1  line buffer shift enable.
- lb_data  output  DEPTH  line buffer shift-in data.
- rgb_valid  output  1  one-cycle strobe; R/G/B/out_x/out_y valid.
- red  output  DEPTH  red channel.
- green  output  DEPTH  averaged green channel.
- blue  output  DEPTH  blue channel.
- out_x  output  11  half-res column, 0..WIDTH/2-1.
- out_y  output  11  half-res row, 0..HEIGHT/2-1.
- frame_done  output  1  one-cycle strobe, coincident with rgb_valid of the last quad.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: col_cnt, row_cnt, held registers and all registered outputs are 0. Reset mid-frame discards the partial quad; the next accepted pixel is (0,0).
- Line buffer feed (combinational, no latency): lb_shift = pix_valid; lb_data = pix_data.
- Counters advance only on pix_valid:
  - col_cnt counts 0..WIDTH-1, then wraps to 0 and increments row_cnt.
  - row_cnt counts 0..HEIGHT-1, then wraps to 0.
- frame_start: forces col_cnt = row_cnt = 0. If it coincides with pix_valid, that pixel is treated as (0,0) and the counters then move to (0,1). frame_start has priority over the wrap logic.
- Held registers: on pix_valid with col_cnt even, latch pix_data into hold_cur and lb_tap0 into hold_prev.
- Bayer pattern is GRBG: (even row, even col)=G1, (even,odd)=R, (odd,even)=B, (odd,odd)=G2.
- Quad completes on pix_valid with row_cnt odd and col_cnt odd. Sources at that point:
  - G1 = hold_prev
  - R = lb_tap0
  - B = hold_cur
  - G2 = pix_data
- Outputs, registered and valid on the next edge (latency 1 cycle from the completing pixel):
  - red = R; blue = B.
  - green = (G1+G2)>>1, using a DEPTH+1-bit sum; truncate, no rounding.
  - out_x = col_cnt>>1; out_y = row_cnt>>1.
- rgb_valid: high for exactly one cycle per quad; low at all other times. Channel and coordinate outputs hold their last values while rgb_valid is low.
- frame_done: asserted with rgb_valid when the completing pixel is (HEIGHT-1, WIDTH-1).
- Even rows: accepted and counted, but never emit output (row 0 only primes the line buffer).
- pix_valid gaps: any number of idle cycles between pixels has no effect on the result.
- Throughput: one pixel per cycle sustained; at most WIDTH*HEIGHT/4 rgb_valid strobes per frame.

Test Plan:
- Reset with pix_valid=0 -> all outputs 0 and lb_shift=0; assert rst_n low mid-row then resume from frame_start -> no rgb_valid until the new row 1, col 1.
- WIDTH=4, HEIGHT=4 override; stream samples = 16*r+c, with a line buffer model supplying lb_tap0 -> first rgb_valid 1 cycle after (1,1). Required values: red=1, blue=16, green=(0+17)>>1=8, out_x=0, out_y=0.
- Same stream, all 16 pixels -> exactly 4 rgb_valid pulses at (0,0),(1,0),(0,1),(1,1); frame_done only on the 4th; the 4th has red=35, blue=50, green=(34+51)>>1=42.
- G1=G2=0xFFF -> green=0xFFF (no overflow); G1=0xFFF, G2=0x000 -> green=0x7FF.
- Random pix_valid gaps (1-5 idle cycles) on the 4x4 stream -> identical output sequence; lb_shift mirrors pix_valid cycle-for-cycle.
- frame_start asserted together with pix_valid at pixel (2,3) -> that pixel counted as (0,0); the next output pulse occurs at the new (1,1) with out_x=0, out_y=0.
